// File: rtl/mux16_arb_pkg.sv
// Shared types and constants for the mux16 round-robin arbiter.
// Requester index equals the mux16 sel code it owns.
package mux16_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        GRANT   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_A  = 2'd0;
    localparam logic [1:0] SEL_B  = 2'd1;
    localparam logic [1:0] SEL_RS = 2'd2;
    localparam int         NREQ   = 3;

    function automatic logic [NREQ-1:0] owner_onehot(input logic [1:0] idx);
        case (idx)
            SEL_A:   return 3'b001;
            SEL_B:   return 3'b010;
            SEL_RS:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mux16_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: search starts one past the last
// winner and wraps; win is meaningless when any is low.
module rr_pick
    import mux16_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [1:0]      win,
    output logic            any
);

    always_comb begin
        any = |req;
        win = SEL_A;
        case (last)
            SEL_A: begin
                if (req[1])      win = SEL_B;
                else if (req[2]) win = SEL_RS;
                else             win = SEL_A;
            end
            SEL_B: begin
                if (req[2])      win = SEL_RS;
                else if (req[0]) win = SEL_A;
                else             win = SEL_B;
            end
            default: begin
                if (req[0])      win = SEL_A;
                else if (req[1]) win = SEL_B;
                else             win = SEL_RS;
            end
        endcase
    end

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter/sequencer driving mux16 sel and rs_new.
// Define MUX16_ARB_TIMEOUT_EN to build the MAX_HOLD grant timeout.
module mux16_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            rs_new,
    output logic            busy
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t          state, state_n;
    logic [1:0]      owner, owner_n;
    logic [1:0]      win;
    logic            any;
    logic            owner_req;
    logic            timeout;
    logic [NREQ-1:0] gnt_n;
    logic [1:0]      sel_n;
    logic            rs_new_n;
    logic            busy_n;

    // owner doubles as last_owner: it keeps the most recent winner after release
    rr_pick u_pick (
        .req  (req),
        .last (owner),
        .win  (win),
        .any  (any)
    );

    assign owner_req = |(req & owner_onehot(owner));

`ifdef MUX16_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout = (hold_cnt == HOLD_LAST) && |(req & ~owner_onehot(owner));

    // Saturating at HOLD_LAST keeps a lone owner granted yet able to time out later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (state == GRANT && state_n == GRANT) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end else begin
            hold_cnt <= 8'd0;
        end
    end
`else
    logic hold_unused;

    assign hold_unused = ^HOLD_LAST;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_n = state;
        owner_n = owner;
        case (state)
            IDLE: begin
                if (any) begin
                    owner_n = win;
                    state_n = (win == SEL_RS) ? CAPTURE : GRANT;
                end
            end
            CAPTURE: state_n = req[2] ? GRANT : IDLE;
            GRANT:   if (!owner_req || timeout) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from next state so they change on the same edge as state
    always_comb begin
        gnt_n    = '0;
        sel_n    = sel;
        rs_new_n = 1'b0;
        busy_n   = (state_n != IDLE);
        case (state_n)
            CAPTURE: begin
                sel_n    = SEL_RS;
                rs_new_n = 1'b1;
            end
            GRANT: begin
                gnt_n = owner_onehot(owner_n);
                sel_n = owner_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= SEL_RS;
            gnt    <= '0;
            sel    <= SEL_A;
            rs_new <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            gnt    <= gnt_n;
            sel    <= sel_n;
            rs_new <= rs_new_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Round-robin arbiter and sequencer for the SISC 16-bit three-input datapath mux (`mux16`). It shares the mux output between three requesters:
- requester 0 owns input A (sel 0);
- requester 1 owns input B (sel 1);
- requester 2 owns the held Rs value (sel 2).

For requester 2 it first drives the one-cycle `rs_new` pulse that makes the mux capture Rs, and only then grants the path. The block sits beside `mux16` in the datapath and drives its `sel` and `rs_new` pins directly.

## Interface
Parameters:
- MAX_HOLD, 8: maximum cycles one owner may keep a grant while another request is pending. Used only when timeout is compiled in (see Configuration). Range 2..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  3  request per requester. Held high for as long as the requester needs the path.
- gnt  out  3  one-hot grant. All zero when no requester owns the path.
- sel  out  2  drives `mux16.sel`. Encoding: 0 = A, 1 = B, 2 = Rs. The value 3 is never driven.
- rs_new  out  1  drives `mux16.rs_new`. Registered, one-cycle pulse.
- busy  out  1  high whenever the state is not IDLE.

## Operation
States:
- **IDLE**
  - If `req` is zero, stay in IDLE.
  - Otherwise pick a winner by round-robin. The search starts at (last_owner+1) mod 3 and wraps.
  - Winner 0 or 1: go to GRANT.
  - Winner 2: go to CAPTURE.
  - `last_owner` is updated to the winner.
- **CAPTURE** (requester 2 only)
  - `rs_new` = 1 and `sel` = 2; `gnt` stays 0.
  - Next state is GRANT if `req[2]` is still high, otherwise IDLE.
  - The pulse always completes, even if the request was withdrawn.
- **GRANT**
  - `gnt[owner]` = 1 and `sel` = owner.
  - If `req[owner]` = 0 at the clock edge, go to IDLE.
  - Otherwise stay, subject to the timeout rule in Configuration.
- Outputs are registered and are decoded from the next-state logic, so each output changes on the same edge as its state.
- `sel` keeps its last value in IDLE. The mux output does not glitch between owners.
- There is no direct GRANT-to-GRANT handoff. Every ownership change passes through one IDLE cycle.
- Requests that arrive while busy are ignored until the next IDLE evaluation. No request is ever lost as long as `req` stays high.
- Several requests in the same cycle: round-robin order decides. Ties are impossible.
- Reset values:
  - `gnt` = 0, `sel` = 0, `rs_new` = 0, `busy` = 0
  - state = IDLE, `last_owner` = 2 (so requester 0 wins first after reset)
  - hold counter = 0
- Reset asserted mid-operation (CAPTURE or GRANT): all outputs clear immediately (asynchronous). No pulse or grant resumes after reset.

## Timing
- Requester 0/1:
  - `req` high, sampled at edge k in IDLE.
  - `gnt` and `sel` are valid after edge k+1.
  - Latency: 1 cycle.
- Requester 2:
  - `rs_new` high after edge k+1; the mux captures Rs on this rising edge.
  - `rs_new` low and `gnt[2]` high after edge k+2.
  - Latency: 2 cycles.
- Release:
  - `req[owner]` low at edge m: `gnt` = 0 and `busy` = 0 after edge m+1.
  - The next winner's grant appears after edge m+2 at the earliest.
- `rs_new` is never high for more than one cycle. It is never high in any state other than CAPTURE.
- At most one `gnt` bit is ever high.

## Configuration
- `MUX16_ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle the state stays in GRANT.
  - When the count equals MAX_HOLD−1 and any other requester's `req` is high, the next state is forced to IDLE regardless of `req[owner]`.
  - If no other request is pending, the counter saturates and the grant continues.
- Not defined:
  - No counter is built; MAX_HOLD is ignored.
  - An owner keeps the grant until it drops `req`.

## Structure
- Package `mux16_arb_pkg`:
  - state enum (IDLE, CAPTURE, GRANT);
  - constants SEL_A = 2'd0, SEL_B = 2'd1, SEL_RS = 2'd2, NREQ = 3.
- Sub-module `rr_pick`:
  - combinational 3-way round-robin priority picker;
  - inputs: `req[2:0]`, `last[1:0]`; outputs: `win[1:0]`, `any`.

## Test plan
- Reset, then `req` = 3'b001 → `gnt` = 001 and `sel` = 0 one cycle later; `req` = 0 → `gnt` = 000 next cycle, `sel` stays 0.
- `req` = 3'b100 → `rs_new` = 1 for exactly one cycle with `sel` = 2 and `gnt` = 0, then `gnt` = 100; a bench `mux16` output equals the `rs_in` value present at the pulse.
- `req` = 3'b111 held, each owner dropping its `req` after 3 cycles of grant, then re-raising it → grant order 0, 1, 2, 0, with exactly one IDLE cycle between consecutive grants.
- Requester 1 granted; assert `rst` asynchronously mid-cycle → `gnt`, `sel`, `rs_new`, `busy` all 0 before the next edge; next grant after reset goes to requester 0 if `req` = 011.
- `MUX16_ARB_TIMEOUT_EN`, MAX_HOLD = 4, `req[0]` held forever, `req[1]` raised at cycle 1 of the grant → `gnt[0]` drops after 4 grant cycles and `gnt[1]` follows after the IDLE bubble. Without the macro, `gnt[0]` persists for 100 cycles.
- `req[2]` dropped during CAPTURE → pulse completes, then IDLE, `gnt` stays 000.
